sys_ctrl_frame: RTL
===================

// Module: sys_ctrl_frame
// PURPOSE
//  Parametrised frame-level system controller between the UART RX/TX datapaths, register file, ALU and TX FIFO.
//  Decodes command frames, then performs one of: register write, register read, burst write, ALU op with operands, ALU op without operands.
//  Results are pushed to the TX FIFO byte-wise with FIFO_FULL backpressure.
//  Adds over the previous controller: width/depth parameters, burst write with address wrap, inter-byte timeout, error reporting.
// PARAMETERS
//  DATA_W    8    byte width of RX/TX/register data
//  ADDR_W    4    register-file address width
//  OPA_ADDR  0    register address written by the ALU operand A byte
//  OPB_ADDR  1    register address written by the ALU operand B byte
//  TIMEOUT   255  max cycles waiting for the next frame byte or for RD_DATA_VLD/OUT_VALID (>=2)
//  ERR_CODE  8'hFF byte pushed to TX on unknown command
// PORTS
//  CLK          in   1         system clock
//  RST          in   1         asynchronous reset, active-low
//  RX_P_DATA    in   DATA_W    received byte
//  RX_D_VLD     in   1         1-cycle strobe: RX_P_DATA valid
//  RD_DATA      in   DATA_W    register-file read data
//  RD_DATA_VLD  in   1         read data valid strobe
//  ALU_OUT      in   2*DATA_W  ALU result
//  OUT_VALID    in   1         ALU result valid strobe
//  FIFO_FULL    in   1         TX FIFO full
//  ADDRESS      out  ADDR_W    register-file address
//  WR_EN        out  1         register write strobe
//  WR_DATA      out  DATA_W    register write data
//  RD_EN        out  1         register read strobe
//  ALU_EN       out  1         ALU start strobe
//  ALU_FUN      out  4         ALU function code
//  CLK_EN       out  1         ALU clock-gate enable
//  TX_P_DATA    out  DATA_W    byte to TX FIFO
//  TX_D_VLD     out  1         TX FIFO write strobe
//  ERR          out  1         1-cycle pulse: timeout or unknown command
//  BUSY         out  1         high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal address/count/result registers 0.
//  Commands (first byte): AA=WR[addr,data], BB=RD[addr], CC=ALU[A,B,fun], DD=ALU[fun], EE=BURST[addr,N,d0..dN-1].
//  Other first byte: ERR pulse; ERR_CODE queued for TX; return to IDLE.
//  States: IDLE, CMD, GET_ADDR, GET_DATA, GET_CNT, BURST_DATA, RD_WAIT, OPA, OPB, GET_FUN, ALU_WAIT, TX_LO, TX_HI, TX_ERR.
//  A frame byte is consumed only in the cycle RX_D_VLD=1. Decode is registered: 1 cycle from byte accept to strobe.
//  WR/OPA/OPB/burst data: WR_EN=1 for exactly 1 cycle, with ADDRESS and WR_DATA held valid in that cycle.
//    OPA writes OPA_ADDR; OPB writes OPB_ADDR.
//  RD: RD_EN 1 cycle with ADDRESS. Wait for RD_DATA_VLD, latch RD_DATA, go TX_LO (1 byte only).
//  ALU fun byte: ALU_EN=1 for 1 cycle with ALU_FUN=byte[3:0]. CLK_EN=1 from the fun byte until OUT_VALID.
//    On OUT_VALID: latch ALU_OUT, send low byte (TX_LO), then high byte (TX_HI).
//  BURST: N=0 -> IDLE, no write.
//    Else N writes at addr, addr+1, ... ; address wraps mod 2^ADDR_W; IDLE after the Nth write.
//  TX: TX_D_VLD = pending & !FIFO_FULL (combinational gate); TX_P_DATA is stable while pending.
//    A byte counts as sent at the edge where TX_D_VLD=1.
//    Stay in TX_x while FIFO_FULL, with no byte lost or duplicated.
//  RX_D_VLD during TX_x/RD_WAIT/ALU_WAIT: byte is ignored (no buffering).
//  Timeout counter: clears on each state change and on each RX_D_VLD; counts in every state except IDLE and TX_x.
//    Reaching TIMEOUT: ERR pulse; all strobes 0; go IDLE; partial frame discarded; writes already done are kept.
//  RX_D_VLD in the same cycle as the timeout: the timeout wins and the byte is dropped.
//  Reset mid-frame: immediate IDLE; no pending TX byte survives.
// TESTING
//  AA,05,3C -> one WR_EN pulse, ADDRESS=5, WR_DATA=3C; no TX; BUSY low afterwards.
//  BB,05, RD_DATA=3C after 3 cycles -> RD_EN with ADDRESS=5; TX_D_VLD once with 3C.
//  CC,12,34,00, ALU_OUT=0046 -> writes 12@0 and 34@1; ALU_EN with FUN=0; TX 46 then 00.
//  EE,0E,03,A1,A2,A3 -> writes A1@E, A2@F, A3@0 (wrap); EE,02,00 -> no write.
//  DD,01 with FIFO_FULL held high 10 cycles at TX -> exactly 2 TX strobes after release, order lo,hi.
//  AA,05 then silence TIMEOUT cycles -> ERR pulse, IDLE, no WR_EN; 77 -> ERR pulse and TX FF.

Source files
------------

// File: rtl/sys_ctrl_frame.sv
`default_nettype none
// ============================================================================
// Module : sys_ctrl_frame
// Frame-level command controller between UART RX/TX, register file and ALU.
// Rev    : 1.0  initial parametrised release with burst, timeout and error
// ============================================================================
module sys_ctrl_frame #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                OPA_ADDR = 0,
    parameter int                OPB_ADDR = 1,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_CODE = DATA_W'('hFF)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DATA_W-1:0]   RX_P_DATA,
    input  logic                RX_D_VLD,
    input  logic [DATA_W-1:0]   RD_DATA,
    input  logic                RD_DATA_VLD,
    input  logic [2*DATA_W-1:0] ALU_OUT,
    input  logic                OUT_VALID,
    input  logic                FIFO_FULL,
    output logic [ADDR_W-1:0]   ADDRESS,
    output logic                WR_EN,
    output logic [DATA_W-1:0]   WR_DATA,
    output logic                RD_EN,
    output logic                ALU_EN,
    output logic [3:0]          ALU_FUN,
    output logic                CLK_EN,
    output logic [DATA_W-1:0]   TX_P_DATA,
    output logic                TX_D_VLD,
    output logic                ERR,
    output logic                BUSY
);
    localparam int                TMO_W         = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  c_TMO_LAST    = TMO_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] c_CMD_WR      = DATA_W'('hAA);
    localparam logic [DATA_W-1:0] c_CMD_RD      = DATA_W'('hBB);
    localparam logic [DATA_W-1:0] c_CMD_ALU_OP  = DATA_W'('hCC);
    localparam logic [DATA_W-1:0] c_CMD_ALU_NOP = DATA_W'('hDD);
    localparam logic [DATA_W-1:0] c_CMD_BURST   = DATA_W'('hEE);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CNT, S_BURST_DATA, S_RD_WAIT,
        S_OPA, S_OPB, S_GET_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI, S_TX_ERR
    } state_t;

    state_t              r_state, w_state_n;
    logic [DATA_W-1:0]   r_cmd, w_cmd_n;
    logic [ADDR_W-1:0]   r_addr, w_addr_n;
    logic [DATA_W-1:0]   r_cnt, w_cnt_n;
    logic [2*DATA_W-1:0] r_result, w_result_n;
    logic                r_two, w_two_n;
    logic [TMO_W-1:0]    r_tmo;
    logic [ADDR_W-1:0]   w_address_n;
    logic [DATA_W-1:0]   w_wr_data_n;
    logic [3:0]          w_alu_fun_n;
    logic                w_wr_en_n, w_rd_en_n, w_alu_en_n, w_clk_en_n, w_err_n;
    logic                w_tx_state, w_counting, w_timeout;

    assign w_tx_state = (r_state == S_TX_LO) || (r_state == S_TX_HI) || (r_state == S_TX_ERR);
    assign w_counting = (r_state != S_IDLE) && !w_tx_state;
    assign w_timeout  = w_counting && (r_tmo == c_TMO_LAST);
    assign TX_D_VLD   = w_tx_state && !FIFO_FULL;
    assign BUSY       = (r_state != S_IDLE);

    always_comb begin
        TX_P_DATA = '0;
        case (r_state)
            S_TX_LO:  TX_P_DATA = r_result[DATA_W-1:0];
            S_TX_HI:  TX_P_DATA = r_result[2*DATA_W-1:DATA_W];
            S_TX_ERR: TX_P_DATA = ERR_CODE;
            default:  TX_P_DATA = '0;
        endcase
    end

    // Strobes are computed here and registered, giving one cycle from byte accept to strobe
    always_comb begin
        w_state_n   = r_state;
        w_cmd_n     = r_cmd;
        w_addr_n    = r_addr;
        w_cnt_n     = r_cnt;
        w_result_n  = r_result;
        w_two_n     = r_two;
        w_address_n = ADDRESS;
        w_wr_data_n = WR_DATA;
        w_alu_fun_n = ALU_FUN;
        w_clk_en_n  = CLK_EN;
        w_wr_en_n   = 1'b0;
        w_rd_en_n   = 1'b0;
        w_alu_en_n  = 1'b0;
        w_err_n     = 1'b0;
        if (w_timeout) begin
            w_state_n  = S_IDLE;
            w_err_n    = 1'b1;
            w_clk_en_n = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (RX_D_VLD) begin
                    w_cmd_n   = RX_P_DATA;
                    w_state_n = S_CMD;
                end
                S_CMD: case (r_cmd)
                    c_CMD_WR, c_CMD_RD, c_CMD_BURST: w_state_n = S_GET_ADDR;
                    c_CMD_ALU_OP:                    w_state_n = S_OPA;
                    c_CMD_ALU_NOP:                   w_state_n = S_GET_FUN;
                    default: begin
                        w_state_n = S_TX_ERR;
                        w_err_n   = 1'b1;
                    end
                endcase
                S_GET_ADDR: if (RX_D_VLD) begin
                    w_addr_n = ADDR_W'(RX_P_DATA);
                    if (r_cmd == c_CMD_WR) begin
                        w_state_n = S_GET_DATA;
                    end else if (r_cmd == c_CMD_RD) begin
                        w_rd_en_n   = 1'b1;
                        w_address_n = ADDR_W'(RX_P_DATA);
                        w_state_n   = S_RD_WAIT;
                    end else begin
                        w_state_n = S_GET_CNT;
                    end
                end
                S_GET_DATA: if (RX_D_VLD) begin
                    w_wr_en_n   = 1'b1;
                    w_address_n = r_addr;
                    w_wr_data_n = RX_P_DATA;
                    w_state_n   = S_IDLE;
                end
                S_GET_CNT: if (RX_D_VLD) begin
                    w_cnt_n   = RX_P_DATA;
                    w_state_n = (RX_P_DATA == '0) ? S_IDLE : S_BURST_DATA;
                end
                S_BURST_DATA: if (RX_D_VLD) begin
                    w_wr_en_n   = 1'b1;
                    w_address_n = r_addr;
                    w_wr_data_n = RX_P_DATA;
                    w_addr_n    = r_addr + ADDR_W'(1);
                    w_cnt_n     = r_cnt - DATA_W'(1);
                    if (r_cnt == DATA_W'(1)) w_state_n = S_IDLE;
                end
                S_RD_WAIT: if (RD_DATA_VLD) begin
                    w_result_n = {{DATA_W{1'b0}}, RD_DATA};
                    w_two_n    = 1'b0;
                    w_state_n  = S_TX_LO;
                end
                S_OPA: if (RX_D_VLD) begin
                    w_wr_en_n   = 1'b1;
                    w_address_n = ADDR_W'(OPA_ADDR);
                    w_wr_data_n = RX_P_DATA;
                    w_state_n   = S_OPB;
                end
                S_OPB: if (RX_D_VLD) begin
                    w_wr_en_n   = 1'b1;
                    w_address_n = ADDR_W'(OPB_ADDR);
                    w_wr_data_n = RX_P_DATA;
                    w_state_n   = S_GET_FUN;
                end
                S_GET_FUN: if (RX_D_VLD) begin
                    w_alu_en_n  = 1'b1;
                    w_alu_fun_n = RX_P_DATA[3:0];
                    w_clk_en_n  = 1'b1;
                    w_state_n   = S_ALU_WAIT;
                end
                S_ALU_WAIT: if (OUT_VALID) begin
                    w_result_n = ALU_OUT;
                    w_two_n    = 1'b1;
                    w_clk_en_n = 1'b0;
                    w_state_n  = S_TX_LO;
                end
                S_TX_LO:  if (!FIFO_FULL) w_state_n = r_two ? S_TX_HI : S_IDLE;
                S_TX_HI:  if (!FIFO_FULL) w_state_n = S_IDLE;
                S_TX_ERR: if (!FIFO_FULL) w_state_n = S_IDLE;
                default:  w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_cmd    <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_two    <= 1'b0;
            r_tmo    <= '0;
            ADDRESS  <= '0;
            WR_EN    <= 1'b0;
            WR_DATA  <= '0;
            RD_EN    <= 1'b0;
            ALU_EN   <= 1'b0;
            ALU_FUN  <= '0;
            CLK_EN   <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cmd    <= w_cmd_n;
            r_addr   <= w_addr_n;
            r_cnt    <= w_cnt_n;
            r_result <= w_result_n;
            r_two    <= w_two_n;
            // Counter restarts on any state change or received byte
            if (!w_counting || (w_state_n != r_state) || RX_D_VLD) r_tmo <= '0;
            else                                                   r_tmo <= r_tmo + TMO_W'(1);
            ADDRESS  <= w_address_n;
            WR_EN    <= w_wr_en_n;
            WR_DATA  <= w_wr_data_n;
            RD_EN    <= w_rd_en_n;
            ALU_EN   <= w_alu_en_n;
            ALU_FUN  <= w_alu_fun_n;
            CLK_EN   <= w_clk_en_n;
            ERR      <= w_err_n;
        end
    end
endmodule
`default_nettype wire
